jesd204b_rx_lane_sync: RTL and testbench

Per-lane JESD204B receive link-layer synchroniser. It sits directly downstream of the GTY receive channel in `jesd204b_rx_con` and consumes one lane's 32-bit decoded user data together with its 8b/10b control flags. It runs code group synchronisation (CGS) and drives the active-low SYNC~ request. It then locks the frame byte alignment on the first ILAS character, checks the 4-multiframe ILAS, and presents byte-aligned data to the downstream transport and lane-alignment stage.

---
 rtl/jesd204b_rx_lane_sync.sv | 206 ++++++++++++++++++++
 tb/tb_jesd204b_rx_lane_sync.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_rx_lane_sync.sv
// Per-lane JESD204B receive synchroniser: CGS with SYNC~ request, ILAS byte-alignment lock,
// ILAS multiframe marker checking and frame-aligned data output with two-cycle latency.
module jesd204b_rx_lane_sync #(
    parameter int FRAME_SIZE = 1,
    parameter int FMLC_NUM   = 8,
    parameter int CGS_WORDS  = 2,
    parameter int ERR_WORDS  = 3
) (
    input  logic        i_rxusrclk2,
    input  logic        i_rst,
    input  logic        i_link_up,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_charisk,
    input  logic [3:0]  i_disperr,
    input  logic [3:0]  i_notintable,
    output logic        o_nsync,
    output logic [31:0] o_data,
    output logic [3:0]  o_charisk,
    output logic        o_valid,
    output logic        o_ilas_done,
    output logic [1:0]  o_align_offset,
    output logic [1:0]  o_state,
    output logic        o_ilas_err
);

    localparam int MFW        = FRAME_SIZE * FMLC_NUM / 4;
    localparam int ILAS_WORDS = 4 * MFW;
    localparam int WCNT_W     = $clog2(ILAS_WORDS);
    localparam int FPOS_W     = (MFW > 1) ? $clog2(MFW) : 1;
    localparam int KCNT_W     = $clog2(CGS_WORDS + 1);
    localparam int ECNT_W     = $clog2(ERR_WORDS + 1);

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(ILAS_WORDS - 1);
    localparam logic [FPOS_W-1:0] FPOS_LAST = FPOS_W'(MFW - 1);
    localparam logic [KCNT_W-1:0] KCNT_LAST = KCNT_W'(CGS_WORDS - 1);
    localparam logic [ECNT_W-1:0] ECNT_LAST = ECNT_W'(ERR_WORDS - 1);

    localparam logic [7:0] CH_K = 8'hBC;
    localparam logic [7:0] CH_R = 8'h1C;
    localparam logic [7:0] CH_A = 8'h7C;

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_WAIT_ILAS = 2'd1,
        ST_ILAS      = 2'd2,
        ST_DATA      = 2'd3
    } state_t;

    state_t              r_state;
    logic [31:0]         r_prev_data;
    logic [3:0]          r_prev_k;
    logic [31:0]         r_data;
    logic [3:0]          r_charisk;
    logic                r_nsync;
    logic                r_valid;
    logic                r_ilas_done;
    logic                r_ilas_err;
    logic [1:0]          r_offset;
    logic [KCNT_W-1:0]   r_kcnt;
    logic [ECNT_W-1:0]   r_ecnt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [FPOS_W-1:0]   r_fpos;

    logic [3:0]  w_byte_k;
    logic [3:0]  w_byte_r;
    logic [3:0]  w_byte_err;
    logic        w_all_k;
    logic        w_word_err;
    logic [1:0]  w_first_idx;
    logic        w_first_is_r;
    logic [63:0] w_cat_data;
    logic [7:0]  w_cat_k;
    logic [31:0] w_al_data;
    logic [3:0]  w_al_k;
    logic        w_al_r0;
    logic        w_al_a3;
    logic        w_ilas_fail;
    logic        w_err_trip;
    logic        w_go_init;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign w_byte_k[gi]   = i_charisk[gi] && (i_data[8*gi +: 8] == CH_K);
            assign w_byte_r[gi]   = i_charisk[gi] && (i_data[8*gi +: 8] == CH_R);
            assign w_byte_err[gi] = i_disperr[gi] | i_notintable[gi];
        end
    endgenerate

    assign w_all_k    = &w_byte_k;
    assign w_word_err = |w_byte_err;

    // Lowest-indexed non-/K/ byte marks where the ILAS (and thus the frame) starts.
    always_comb begin
        w_first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!w_byte_k[i]) begin
                w_first_idx = 2'(i);
            end
        end
    end
    assign w_first_is_r = w_byte_r[w_first_idx];

    // Older word in the low half so byte k of the previous word becomes aligned byte 0.
    assign w_cat_data = {i_data, r_prev_data};
    assign w_cat_k    = {i_charisk, r_prev_k};
    assign w_al_data  = w_cat_data[{r_offset, 3'b000} +: 32];
    assign w_al_k     = w_cat_k[r_offset +: 4];
    assign w_al_r0    = w_al_k[0] && (w_al_data[7:0] == CH_R);
    assign w_al_a3    = w_al_k[3] && (w_al_data[31:24] == CH_A);

    assign w_ilas_fail = ((r_state == ST_WAIT_ILAS) && !w_all_k && !w_first_is_r) ||
                         ((r_state == ST_ILAS) &&
                          (((r_fpos == '0) && !w_al_r0) || ((r_fpos == FPOS_LAST) && !w_al_a3)));
    assign w_err_trip  = (r_state != ST_INIT) && w_word_err && (r_ecnt == ECNT_LAST);
    assign w_go_init   = !i_link_up || w_ilas_fail || w_err_trip;

    always_ff @(posedge i_rxusrclk2) begin
        if (i_rst) begin
            r_state     <= ST_INIT;
            r_prev_data <= '0;
            r_prev_k    <= '0;
            r_data      <= '0;
            r_charisk   <= '0;
            r_nsync     <= 1'b0;
            r_valid     <= 1'b0;
            r_ilas_done <= 1'b0;
            r_ilas_err  <= 1'b0;
            r_offset    <= '0;
            r_kcnt      <= '0;
            r_ecnt      <= '0;
            r_wcnt      <= '0;
            r_fpos      <= '0;
        end else begin
            r_prev_data <= i_data;
            r_prev_k    <= i_charisk;
            r_data      <= w_al_data;
            r_charisk   <= w_al_k;
            r_valid     <= 1'b0;
            r_ilas_err  <= i_link_up && w_ilas_fail;

            if (i_link_up && (r_state == ST_WAIT_ILAS) && !w_all_k) begin
                r_offset <= w_first_idx;
            end

            if (w_go_init) begin
                r_state     <= ST_INIT;
                r_nsync     <= 1'b0;
                r_ilas_done <= 1'b0;
                r_kcnt      <= '0;
                r_ecnt      <= '0;
                r_wcnt      <= '0;
                r_fpos      <= '0;
            end else begin
                case (r_state)
                    ST_INIT: begin
                        if (w_all_k && !w_word_err) begin
                            if (r_kcnt == KCNT_LAST) begin
                                r_state <= ST_WAIT_ILAS;
                                r_nsync <= 1'b1;
                                r_kcnt  <= '0;
                                r_ecnt  <= '0;
                            end else begin
                                r_kcnt <= r_kcnt + KCNT_W'(1);
                            end
                        end else begin
                            r_kcnt <= '0;
                        end
                    end
                    ST_WAIT_ILAS: begin
                        r_ecnt <= w_word_err ? r_ecnt + ECNT_W'(1) : '0;
                        if (!w_all_k) begin
                            r_state <= ST_ILAS;
                            r_wcnt  <= '0;
                            r_fpos  <= '0;
                        end
                    end
                    ST_ILAS: begin
                        r_ecnt <= w_word_err ? r_ecnt + ECNT_W'(1) : '0;
                        if (r_wcnt == WCNT_LAST) begin
                            r_state     <= ST_DATA;
                            r_ilas_done <= 1'b1;
                        end else begin
                            r_wcnt <= r_wcnt + WCNT_W'(1);
                            r_fpos <= (r_fpos == FPOS_LAST) ? '0 : r_fpos + FPOS_W'(1);
                        end
                    end
                    default: begin
                        r_ecnt  <= w_word_err ? r_ecnt + ECNT_W'(1) : '0;
                        r_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_nsync        = r_nsync;
    assign o_data         = r_data;
    assign o_charisk      = r_charisk;
    assign o_valid        = r_valid;
    assign o_ilas_done    = r_ilas_done;
    assign o_align_offset = r_offset;
    assign o_state        = r_state;
    assign o_ilas_err     = r_ilas_err;

endmodule

// File: tb/tb_jesd204b_rx_lane_sync.sv
// Directed bench for jesd204b_rx_lane_sync: CGS, offset lock, full ILAS, error counting,
// link drop and ILAS marker failures with hand-computed expected outputs.
module tb_jesd204b_rx_lane_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_up;
    logic [31:0] din;
    logic [3:0]  kin;
    logic [3:0]  derr;
    logic [3:0]  nit;
    logic        nsync;
    logic [31:0] dout;
    logic [3:0]  kout;
    logic        valid;
    logic        ilas_done;
    logic [1:0]  offset;
    logic [1:0]  state;
    logic        ilas_err;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] KW = 32'hBCBCBCBC;
    localparam logic [31:0] IL_R = 32'h3322111C;  // byte0 /R/, K=0x1
    localparam logic [31:0] IL_A = 32'h7C665544;  // byte3 /A/, K=0x8

    always #5 clk = ~clk;

    jesd204b_rx_lane_sync dut (
        .i_rxusrclk2    (clk),
        .i_rst          (rst),
        .i_link_up      (link_up),
        .i_data         (din),
        .i_charisk      (kin),
        .i_disperr      (derr),
        .i_notintable   (nit),
        .o_nsync        (nsync),
        .o_data         (dout),
        .o_charisk      (kout),
        .o_valid        (valid),
        .o_ilas_done    (ilas_done),
        .o_align_offset (offset),
        .o_state        (state),
        .o_ilas_err     (ilas_err)
    );

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                        input logic [3:0] ni, input logic lu);
        din     = d;
        kin     = k;
        derr    = de;
        nit     = ni;
        link_up = lu;
        @(posedge clk);
        #1;
        $display("txn in=%08h k=%h de=%h ni=%h lu=%0b -> state=%0d nsync=%0b data=%08h valid=%0b",
                 d, k, de, ni, lu, state, nsync, dout, valid);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; link_up = 1'b1; din = KW; kin = 4'hF; derr = 4'h0; nit = 4'h0;
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_nsync", 32'(nsync), 32'd0);
        chk("rst_data", dout, 32'd0);
        chk("rst_charisk", 32'(kout), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_done", 32'(ilas_done), 32'd0);
        chk("rst_offset", 32'(offset), 32'd0);
        chk("rst_err", 32'(ilas_err), 32'd0);
        rst = 1'b0;

        // CGS with two clean /K/ words
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        chk("cgs1_nsync", 32'(nsync), 32'd0);
        chk("cgs1_state", 32'(state), 32'd0);
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        chk("cgs2_nsync", 32'(nsync), 32'd1);
        chk("cgs2_state", 32'(state), 32'd1);
        send(KW, 4'hF, 4'h0, 4'h0, 1'b0);
        chk("linkdn_wait_state", 32'(state), 32'd0);

        // Disparity error restarts the /K/ counter
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        chk("cgsr1_nsync", 32'(nsync), 32'd0);
        send(KW, 4'hF, 4'h1, 4'h0, 1'b1);
        chk("cgsr2_nsync", 32'(nsync), 32'd0);
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        chk("cgsr3_nsync", 32'(nsync), 32'd0);
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        chk("cgsr4_nsync", 32'(nsync), 32'd1);
        chk("cgsr4_state", 32'(state), 32'd1);

        // ILAS start at byte offset 2
        send(32'hAA1CBCBC, 4'h7, 4'h0, 4'h0, 1'b1);
        chk("off2_state", 32'(state), 32'd2);
        chk("off2_offset", 32'(offset), 32'd2);
        chk("off2_err", 32'(ilas_err), 32'd0);
        send(32'h00000000, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("off2_data", dout, 32'h0000AA1C);
        chk("off2_charisk", 32'(kout), 32'h1);
        chk("off2_state2", 32'(state), 32'd2);
        // link drop mid-ILAS outranks the missing /A/
        send(KW, 4'hF, 4'h0, 4'h0, 1'b0);
        chk("ilas_linkdn_state", 32'(state), 32'd0);
        chk("ilas_linkdn_nsync", 32'(nsync), 32'd0);
        chk("ilas_linkdn_err", 32'(ilas_err), 32'd0);
        chk("ilas_linkdn_offset_hold", 32'(offset), 32'd2);

        // Full ILAS at offset 0
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        chk("full_wait_state", 32'(state), 32'd1);
        send(IL_R, 4'h1, 4'h0, 4'h0, 1'b1);
        chk("full_lock_state", 32'(state), 32'd2);
        chk("full_lock_offset", 32'(offset), 32'd0);
        send(IL_A, 4'h8, 4'h0, 4'h0, 1'b1);
        chk("full_w0_data", dout, IL_R);
        chk("full_w0_state", 32'(state), 32'd2);
        for (int m = 0; m < 3; m++) begin
            send(IL_R, 4'h1, 4'h0, 4'h0, 1'b1);
            send(IL_A, 4'h8, 4'h0, 4'h0, 1'b1);
        end
        chk("full_pre_state", 32'(state), 32'd2);
        chk("full_pre_done", 32'(ilas_done), 32'd0);
        send(32'h11223344, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("full_last_state", 32'(state), 32'd3);
        chk("full_last_done", 32'(ilas_done), 32'd1);
        chk("full_last_valid", 32'(valid), 32'd0);
        chk("full_last_data", dout, IL_A);
        send(32'h55667788, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("data1_valid", 32'(valid), 32'd1);
        chk("data1_data", dout, 32'h11223344);
        chk("data1_charisk", 32'(kout), 32'h0);

        // Two error words then a clean word keeps DATA
        send(32'h01020304, 4'h0, 4'h2, 4'h0, 1'b1);
        chk("e1_state", 32'(state), 32'd3);
        chk("e1_data", dout, 32'h55667788);
        send(32'h05060708, 4'h0, 4'h0, 4'h1, 1'b1);
        chk("e2_state", 32'(state), 32'd3);
        send(32'h090A0B0C, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("e2c_state", 32'(state), 32'd3);
        chk("e2c_valid", 32'(valid), 32'd1);
        // Three consecutive error words force INIT
        send(32'h0D0E0F10, 4'h0, 4'h4, 4'h0, 1'b1);
        send(32'h11121314, 4'h0, 4'h0, 4'h8, 1'b1);
        chk("e3b_state", 32'(state), 32'd3);
        send(32'h15161718, 4'h0, 4'h1, 4'h0, 1'b1);
        chk("e3_state", 32'(state), 32'd0);
        chk("e3_nsync", 32'(nsync), 32'd0);
        chk("e3_valid", 32'(valid), 32'd0);
        chk("e3_done", 32'(ilas_done), 32'd0);
        chk("e3_err", 32'(ilas_err), 32'd0);

        // Multiframe 1 ends with /K/ instead of /A/
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        send(IL_R, 4'h1, 4'h0, 4'h0, 1'b1);
        send(32'hBC665544, 4'h8, 4'h0, 4'h0, 1'b1);
        chk("badA_pre_state", 32'(state), 32'd2);
        send(IL_R, 4'h1, 4'h0, 4'h0, 1'b1);
        chk("badA_state", 32'(state), 32'd0);
        chk("badA_err", 32'(ilas_err), 32'd1);
        chk("badA_nsync", 32'(nsync), 32'd0);
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        chk("badA_err_drop", 32'(ilas_err), 32'd0);

        // First non-/K/ byte at offset 1 that is not /R/
        send(KW, 4'hF, 4'h0, 4'h0, 1'b1);
        chk("badR_wait_state", 32'(state), 32'd1);
        send(32'hBCBC55BC, 4'hD, 4'h0, 4'h0, 1'b1);
        chk("badR_state", 32'(state), 32'd0);
        chk("badR_err", 32'(ilas_err), 32'd1);
        chk("badR_offset", 32'(offset), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
